health_bar: RTL
===============

Name: health_bar

Overview:
- Player health state keeper and on-screen health-bar pixel generator.
- Sits directly upstream of color_mapper and drives its is_blood / blood_index inputs.
- Tracks HP from damage/heal events, animates a lagging "ghost" segment and a hit flash on the game frame tick, and classifies each VGA pixel against the bar geometry.

Parameters:
- MAX_HP, 100: full health; the bar interior is MAX_HP pixels wide (1 px per HP).
- BAR_X, 20: left x of the outer bar border.
- BAR_Y, 10: top y of the outer bar border.
- BAR_H, 8: interior height in pixels.
- FLASH_FRAMES, 8: frame ticks the hit flash lasts.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-Clk pulse per game frame (game_frame_clk_rising_edge).
- game_restart  in  1  one-Clk pulse; restores full health.
- damage_valid  in  1  damage event strobe.
- damage_amt  in  8  HP to subtract.
- heal_valid  in  1  heal event strobe.
- heal_amt  in  8  HP to add.
- DrawX  in  10  current pixel x.
- DrawY  in  10  current pixel y.
- is_blood  out  1  pixel lies inside the bar, border included.
- blood_index  out  5  palette index for color_mapper.
- hp  out  8  current health.
- player_dead  out  1  high while in DEAD.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-low; all state updates on the posedge of Clk.
- Values on Reset low or game_restart high: hp=MAX_HP, ghost=MAX_HP, flash_cnt=0, state=ALIVE, is_blood=0, blood_index=0, player_dead=0. Reset has priority over every event; a reset in mid-flash or mid-ghost-decay aborts both immediately.
- HP update on a cycle with events: first apply damage, hp=max(hp-damage_amt,0). Then apply heal, hp=min(hp+heal_amt,MAX_HP).
  - Intermediate arithmetic is 9-bit; no wrap.
  - Damage and heal in the same cycle are both applied, in that order.
  - Events are ignored in DEAD.
- Ghost register:
  - It never falls below hp. If hp rises above ghost (heal), ghost=hp in the same cycle hp updates.
  - On each frame_tick with ghost>hp, ghost decrements by 1.
  - Damage does not move ghost.
- State machine:
  - ALIVE -> HIT_FLASH on damage_valid with damage_amt!=0 and resulting hp>0. This loads flash_cnt=FLASH_FRAMES.
  - HIT_FLASH: flash_cnt decrements on frame_tick. At 0, go to ALIVE. A new nonzero damage reloads FLASH_FRAMES.
  - ALIVE or HIT_FLASH -> DEAD when the resulting hp==0, checked before the flash condition.
  - DEAD: only Reset or game_restart leaves it, to ALIVE. player_dead is registered and equals (state==DEAD).
  - damage_amt=0 with damage_valid: no state change.
- Pixel classification (outputs registered; 1 Clk latency from DrawX/DrawY):
  - Outer box: x in [BAR_X, BAR_X+MAX_HP+1], y in [BAR_Y, BAR_Y+BAR_H+1]. Outside the box: is_blood=0, blood_index=0.
  - Box edge rows/columns: border, index 1 (black).
  - Interior offset off=DrawX-BAR_X-1, range 0..MAX_HP-1.
  - off<hp: fill, index 16 (red). In HIT_FLASH with flash_cnt[1]==1, use index 2 (white) instead.
  - hp<=off<ghost: ghost segment, index 18 (dark red).
  - Otherwise: empty, index 17 (grey).
  - In DEAD the whole interior is index 17.
  - Index 0 is never emitted inside the box; color_mapper treats 0 as transparent.
  - Pixel outputs use the state as it stands at that cycle's Clk edge; there is no frame double-buffering.

Decomposition:
- Package health_pkg:
  - state enum {ALIVE, HIT_FLASH, DEAD};
  - palette index constants IDX_BORDER=1, IDX_FLASH=2, IDX_FILL=16, IDX_EMPTY=17, IDX_GHOST=18 (shared with color_mapper);
  - HP width constant = 8.
- Sub-module health_bar_pixel:
  - combinational geometry and index select from DrawX, DrawY, hp, ghost, flash, dead;
  - the top level registers its outputs.

Test Plan:
- Reset low 2 cycles, then high; sample DrawX=BAR_X+50, DrawY=BAR_Y+4 -> hp=100, is_blood=1, blood_index=16 one cycle later. Sample DrawX=BAR_X, same DrawY -> blood_index=1. Sample DrawX=0 -> is_blood=0, blood_index=0.
- damage_amt=30 -> hp=70, state HIT_FLASH, flash_cnt=8. Pixel off=80 -> index 18 (ghost). After 30 frame_ticks, ghost=70 and off=80 -> index 17. After 8 ticks, state ALIVE.
- hp=70; damage 50 and heal 100 in the same cycle -> hp=min(20+100,100)=100, ghost=100, state HIT_FLASH.
- damage_amt=250 at hp=100 -> hp=0, player_dead=1, interior all index 17. A subsequent heal_valid with heal_amt=50 -> hp stays 0.
- In DEAD, pulse game_restart -> next cycle hp=100, ghost=100, player_dead=0, state ALIVE.
- Reset asserted during HIT_FLASH with ghost decaying -> next cycle flash_cnt=0, hp=ghost=100, outputs 0.

Source files
------------

// File: rtl/health_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// health_pkg : shared states, palette indices and widths for the health bar
// Revision   : 1.0
// ---------------------------------------------------------------------------
package health_pkg;

  localparam int HP_W = 8;

  // Palette indices shared with color_mapper; 0 is transparent there.
  localparam logic [4:0] IDX_BORDER = 5'd1;
  localparam logic [4:0] IDX_FLASH  = 5'd2;
  localparam logic [4:0] IDX_FILL   = 5'd16;
  localparam logic [4:0] IDX_EMPTY  = 5'd17;
  localparam logic [4:0] IDX_GHOST  = 5'd18;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    HIT_FLASH = 2'd1,
    DEAD      = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/health_bar_pixel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// health_bar_pixel : combinational bar geometry and palette index select
// Revision         : 1.0
// ---------------------------------------------------------------------------
module health_bar_pixel
  import health_pkg::*;
#(
  parameter int MAX_HP = 100,
  parameter int BAR_X  = 20,
  parameter int BAR_Y  = 10,
  parameter int BAR_H  = 8
) (
  input  logic [9:0]      draw_x,
  input  logic [9:0]      draw_y,
  input  logic [HP_W-1:0] hp,
  input  logic [HP_W-1:0] ghost,
  input  logic            flash,
  input  logic            dead,
  output logic            is_blood,
  output logic [4:0]      blood_index
);

  localparam logic [9:0] X0 = 10'(BAR_X);
  localparam logic [9:0] X1 = 10'(BAR_X + MAX_HP + 1);
  localparam logic [9:0] Y0 = 10'(BAR_Y);
  localparam logic [9:0] Y1 = 10'(BAR_Y + BAR_H + 1);

  logic       in_box;
  logic       on_border;
  logic [9:0] off;

  assign in_box    = (draw_x >= X0) && (draw_x <= X1) && (draw_y >= Y0) && (draw_y <= Y1);
  assign on_border = (draw_x == X0) || (draw_x == X1) || (draw_y == Y0) || (draw_y == Y1);
  assign off       = draw_x - X0 - 10'd1;

  always_comb begin
    is_blood    = 1'b0;
    blood_index = 5'd0;
    if (in_box) begin
      is_blood = 1'b1;
      if (on_border)
        blood_index = IDX_BORDER;
      else if (dead)
        blood_index = IDX_EMPTY;
      else if (off < {2'b00, hp})
        blood_index = flash ? IDX_FLASH : IDX_FILL;
      else if (off < {2'b00, ghost})
        blood_index = IDX_GHOST;
      else
        blood_index = IDX_EMPTY;
    end
  end

endmodule
`default_nettype wire

// File: rtl/health_bar.sv
`default_nettype none
// ---------------------------------------------------------------------------
// health_bar : HP/ghost/flash state keeper feeding color_mapper pixel indices
// Revision   : 1.0
// ---------------------------------------------------------------------------
module health_bar
  import health_pkg::*;
#(
  parameter int MAX_HP       = 100,
  parameter int BAR_X        = 20,
  parameter int BAR_Y        = 10,
  parameter int BAR_H        = 8,
  parameter int FLASH_FRAMES = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            frame_tick,
  input  logic            game_restart,
  input  logic            damage_valid,
  input  logic [7:0]      damage_amt,
  input  logic            heal_valid,
  input  logic [7:0]      heal_amt,
  input  logic [9:0]      DrawX,
  input  logic [9:0]      DrawY,
  output logic            is_blood,
  output logic [4:0]      blood_index,
  output logic [HP_W-1:0] hp,
  output logic            player_dead
);

  localparam int              FC_W   = $clog2(FLASH_FRAMES + 1);
  localparam logic [HP_W-1:0] HP_MAX = HP_W'(MAX_HP);
  localparam logic [8:0]      MAX9   = 9'(MAX_HP);

  state_t          state, state_n;
  logic [HP_W-1:0] hp_n, ghost, ghost_n;
  logic [FC_W-1:0] flash_cnt, flash_n;
  logic [8:0]      dmg9, heal9, after_dmg, after_heal;
  logic            pix_blood;
  logic [4:0]      pix_index;

  // 9-bit saturating arithmetic: damage first, then heal.
  assign dmg9       = damage_valid ? {1'b0, damage_amt} : 9'd0;
  assign heal9      = heal_valid ? {1'b0, heal_amt} : 9'd0;
  assign after_dmg  = (dmg9 >= {1'b0, hp}) ? 9'd0 : ({1'b0, hp} - dmg9);
  assign after_heal = ((after_dmg + heal9) > MAX9) ? MAX9 : (after_dmg + heal9);

  always_comb begin
    state_n = state;
    hp_n    = hp;
    ghost_n = ghost;
    flash_n = flash_cnt;
    if (frame_tick && (ghost > hp))
      ghost_n = ghost - 1'b1;
    if (state != DEAD) begin
      hp_n = after_heal[HP_W-1:0];
      if (hp_n == '0) begin
        state_n = DEAD;
        flash_n = '0;
      end else if (damage_valid && (damage_amt != 8'd0)) begin
        state_n = HIT_FLASH;
        flash_n = FC_W'(FLASH_FRAMES);
      end else if ((state == HIT_FLASH) && frame_tick) begin
        if (flash_cnt <= FC_W'(1)) begin
          flash_n = '0;
          state_n = ALIVE;
        end else begin
          flash_n = flash_cnt - 1'b1;
        end
      end
    end
    if (hp_n > ghost_n)
      ghost_n = hp_n;
    if (game_restart) begin
      state_n = ALIVE;
      hp_n    = HP_MAX;
      ghost_n = HP_MAX;
      flash_n = '0;
    end
  end

  health_bar_pixel #(
    .MAX_HP (MAX_HP),
    .BAR_X  (BAR_X),
    .BAR_Y  (BAR_Y),
    .BAR_H  (BAR_H)
  ) u_pixel (
    .draw_x      (DrawX),
    .draw_y      (DrawY),
    .hp          (hp),
    .ghost       (ghost),
    .flash       ((state == HIT_FLASH) && flash_cnt[1]),
    .dead        (state == DEAD),
    .is_blood    (pix_blood),
    .blood_index (pix_index)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= ALIVE;
      hp          <= HP_MAX;
      ghost       <= HP_MAX;
      flash_cnt   <= '0;
      is_blood    <= 1'b0;
      blood_index <= 5'd0;
      player_dead <= 1'b0;
    end else begin
      state       <= state_n;
      hp          <= hp_n;
      ghost       <= ghost_n;
      flash_cnt   <= flash_n;
      player_dead <= (state_n == DEAD);
      is_blood    <= game_restart ? 1'b0 : pix_blood;
      blood_index <= game_restart ? 5'd0 : pix_index;
    end
  end

endmodule
`default_nettype wire
